// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: gamestate encoding, screen size and
// the collision detector state type.
package dino_pkg;

  typedef enum logic [1:0] {
    GS_READY = 2'b00,
    GS_RUN   = 2'b01,
    GS_DEAD  = 2'b10
  } gamestate_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRACE,
    ST_ARMED,
    ST_HIT
  } cd_state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic inc);
    return (inc && (v != 10'h3FF)) ? v + 10'd1 : v;
  endfunction

endpackage

// File: rtl/frame_tracker.sv
// Pixel-strobe qualifiers: start of frame (pixel 0,0) and visible-area pixel.
module frame_tracker
  import dino_pkg::*;
#(
  parameter int H_ACTIVE = SCREEN_W,
  parameter int V_ACTIVE = SCREEN_H
) (
  input  logic       i_pix_en,
  input  logic [9:0] i_col_addr,
  input  logic [8:0] i_row_addr,
  output logic       o_frame_start,
  output logic       o_active
);

  // One extra bit so a limit of 1024 / 512 is representable.
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  assign o_frame_start = i_pix_en && (i_col_addr == 10'd0) && (i_row_addr == 9'd0);
  assign o_active      = i_pix_en && ({1'b0, i_col_addr} < H_LIM) && ({1'b0, i_row_addr} < V_LIM);

endmodule

// File: rtl/collision_detect.sv
// Glitch-filtered dino/obstacle collision detector: counts overlapping sprite
// pixels per frame and latches a hit (with its first-overlap position).
module collision_detect
  import dino_pkg::*;
#(
  parameter int THRESH       = 4,
  parameter int GRACE_FRAMES = 2,
  parameter int H_ACTIVE     = SCREEN_W,
  parameter int V_ACTIVE     = SCREEN_H
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  input  logic [9:0] i_col_addr,
  input  logic [8:0] i_row_addr,
  input  logic       i_isemptyDino,
  input  logic       i_isemptyObstacle,
  input  logic [1:0] i_gamestate,
  output logic       o_collision,
  output logic [9:0] o_hit_col,
  output logic [8:0] o_hit_row,
  output logic [9:0] o_overlap_cnt
);

  localparam logic [9:0] THRESH_V = 10'(THRESH);
  localparam logic [3:0] GRACE_V  = 4'(GRACE_FRAMES);

  logic       w_frame_start;
  logic       w_active;
  logic       w_ov;
  logic [9:0] w_cnt_next;
  logic       w_thresh_hit;
  logic       w_run;

  cd_state_e  r_state;
  logic [9:0] r_cur_cnt;
  logic [3:0] r_grace;
  logic       r_captured;
  logic       r_collision;
  logic [9:0] r_hit_col;
  logic [8:0] r_hit_row;
  logic [9:0] r_overlap_cnt;

  frame_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tracker (
    .i_pix_en      (i_pix_en),
    .i_col_addr    (i_col_addr),
    .i_row_addr    (i_row_addr),
    .o_frame_start (w_frame_start),
    .o_active      (w_active)
  );

  assign w_ov  = w_active && !i_isemptyDino && !i_isemptyObstacle;
  assign w_run = (i_gamestate == GS_RUN);

  // A frame-start pixel opens the new frame's count rather than extending the old one.
  assign w_cnt_next   = w_frame_start ? {9'd0, w_ov} : sat_inc(r_cur_cnt, w_ov);
  assign w_thresh_hit = w_ov && (w_cnt_next >= THRESH_V);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cur_cnt     <= 10'd0;
      r_grace       <= 4'd0;
      r_captured    <= 1'b0;
      r_collision   <= 1'b0;
      r_hit_col     <= 10'd0;
      r_hit_row     <= 9'd0;
      r_overlap_cnt <= 10'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cur_cnt  <= 10'd0;
          r_grace    <= 4'd0;
          r_captured <= 1'b0;
          if (w_run) begin
            if (GRACE_V == 4'd0) begin
              r_state <= ST_ARMED;
            end else begin
              r_state <= ST_GRACE;
              r_grace <= GRACE_V;
            end
          end
        end

        ST_GRACE, ST_ARMED: begin
          if (!w_run) begin
            r_state    <= ST_IDLE;
            r_cur_cnt  <= 10'd0;
            r_grace    <= 4'd0;
            r_captured <= 1'b0;
          end else if ((r_state == ST_GRACE) && !(w_frame_start && (r_grace == 4'd0))) begin
            if (w_frame_start) begin
              r_grace <= r_grace - 4'd1;
            end
          end else if (i_pix_en) begin
            // Counting pixel: either ARMED, or the frame start that ends the grace period.
            r_state     <= w_thresh_hit ? ST_HIT : ST_ARMED;
            r_collision <= w_thresh_hit;
            r_cur_cnt   <= w_cnt_next;
            r_captured  <= w_frame_start ? w_ov : (r_captured || w_ov);
            if (w_frame_start) begin
              r_overlap_cnt <= r_cur_cnt;
            end
            if (w_ov && (w_frame_start || !r_captured)) begin
              r_hit_col <= i_col_addr;
              r_hit_row <= i_row_addr;
            end
          end
        end

        ST_HIT: begin
          r_collision <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_collision   = r_collision;
  assign o_hit_col     = r_hit_col;
  assign o_hit_row     = r_hit_row;
  assign o_overlap_cnt = r_overlap_cnt;

endmodule

// File: tb/tb_collision_detect.sv
// Directed scoreboard bench for collision_detect (THRESH=4, GRACE_FRAMES=2).
module tb_collision_detect;
  import dino_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] col = 10'd0;
  logic [8:0] row = 9'd0;
  logic       ed = 1'b1;
  logic       eo = 1'b1;
  logic [1:0] gs = GS_READY;
  logic       o_collision;
  logic [9:0] o_hit_col;
  logic [8:0] o_hit_row;
  logic [9:0] o_overlap_cnt;

  always #5 clk = ~clk;

  collision_detect dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_pix_en          (pix_en),
    .i_col_addr        (col),
    .i_row_addr        (row),
    .i_isemptyDino     (ed),
    .i_isemptyObstacle (eo),
    .i_gamestate       (gs),
    .o_collision       (o_collision),
    .o_hit_col         (o_hit_col),
    .o_hit_row         (o_hit_row),
    .o_overlap_cnt     (o_overlap_cnt)
  );

  typedef struct {
    string      name;
    logic       coll;
    bit         chk_pos;
    logic [9:0] hc;
    logic [8:0] hr;
    bit         chk_oc;
    logic [9:0] oc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void cmp(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endfunction

  // Monitor: outputs are registered, so compare on the falling edge after each push.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "collision", 32'(o_collision), 32'(e.coll));
      if (e.chk_pos) begin
        cmp(e.name, "hit_col", 32'(o_hit_col), 32'(e.hc));
        cmp(e.name, "hit_row", 32'(o_hit_row), 32'(e.hr));
      end
      if (e.chk_oc) cmp(e.name, "overlap_cnt", 32'(o_overlap_cnt), 32'(e.oc));
      $display("check %s: coll=%0d col=%0d row=%0d ocnt=%0d", e.name,
               o_collision, o_hit_col, o_hit_row, o_overlap_cnt);
    end
  end

  task automatic expect_out(input string name, input logic c, input bit cp,
                            input logic [9:0] hc, input logic [8:0] hr,
                            input bit co, input logic [9:0] oc);
    exp_t e;
    e.name = name; e.coll = c; e.chk_pos = cp; e.hc = hc; e.hr = hr;
    e.chk_oc = co; e.oc = oc;
    sb.push_back(e);
  endtask

  // dino/obs = sprite present at this pixel
  task automatic drive(input bit pe, input logic [9:0] c, input logic [8:0] r,
                       input bit dino, input bit obs, input bit rs);
    @(negedge clk);
    rst = rs; pix_en = pe; col = c; row = r; ed = ~dino; eo = ~obs;
    @(posedge clk);
  endtask

  task automatic ov(input logic [9:0] c, input logic [8:0] r);
    drive(1'b1, c, r, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic fs(input bit o);
    drive(1'b1, 10'd0, 9'd0, o, o, 1'b0);
  endtask

  task automatic set_gs(input logic [1:0] g);
    @(negedge clk);
    gs = g; pix_en = 1'b0; rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_en = 1'b0; gs = GS_READY;
    @(posedge clk);
  endtask

  // Reset, enter RUN and pass two grace frames; the next frame start arms counting.
  task automatic enter_armed();
    do_reset();
    set_gs(GS_RUN);
    fs(1'b0);
    fs(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    expect_out("reset", 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 10'd0);

    // Three frames without a true overlap
    enter_armed();
    for (int f = 0; f < 3; f++) begin
      fs(1'b0);
      expect_out("no_ov_fs", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd0);
      drive(1'b1, 10'd10, 9'd10, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 10'd11, 9'd10, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 10'd12, 9'd10, 1'b1, 1'b1, 1'b0);
    end
    fs(1'b0);
    expect_out("no_ov_end", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd0);

    // Grace frames ignore heavy overlap, hit in frame 2
    do_reset();
    set_gs(GS_RUN);
    for (int f = 0; f < 2; f++) begin
      fs(1'b1);
      for (int i = 1; i < 10; i++) ov(10'(i), 9'd0);
    end
    expect_out("grace_nohit", 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 10'd0);
    fs(1'b0);
    ov(10'd100, 9'd300);
    ov(10'd101, 9'd300);
    ov(10'd102, 9'd300);
    expect_out("pre_thresh", 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 10'd0);
    ov(10'd103, 9'd300);
    expect_out("hit", 1'b1, 1'b1, 10'd100, 9'd300, 1'b1, 10'd0);

    // Hit survives gamestate changes and further overlaps
    set_gs(GS_DEAD);
    ov(10'd200, 9'd200);
    fs(1'b1);
    set_gs(GS_READY);
    expect_out("hit_hold", 1'b1, 1'b1, 10'd100, 9'd300, 1'b1, 10'd0);
    drive(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1);
    expect_out("rst_after_hit", 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 10'd0);

    // Three overlaps per frame for five frames: never reaches 4
    enter_armed();
    for (int f = 0; f < 5; f++) begin
      fs(1'b1);
      if (f > 0) expect_out("three_fs", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd3);
      ov(10'd20, 9'd40);
      ov(10'd21, 9'd40);
    end
    fs(1'b0);
    expect_out("three_end", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd3);

    // Off-screen overlaps ignored; last visible pixel counts
    enter_armed();
    fs(1'b0);
    ov(10'd700, 9'd10);
    ov(10'd10, 9'd500);
    ov(10'd640, 9'd5);
    ov(10'd5, 9'd480);
    drive(1'b0, 10'd30, 9'd30, 1'b1, 1'b1, 1'b0);
    fs(1'b0);
    expect_out("offscreen", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd0);
    ov(10'd639, 9'd479);
    fs(1'b0);
    expect_out("edge_pixel", 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd1);

    // Reset wins over the threshold-crossing overlap
    enter_armed();
    fs(1'b0);
    ov(10'd50, 9'd60);
    ov(10'd51, 9'd60);
    ov(10'd52, 9'd60);
    expect_out("first_capture", 1'b0, 1'b1, 10'd50, 9'd60, 1'b0, 10'd0);
    drive(1'b1, 10'd53, 9'd60, 1'b1, 1'b1, 1'b1);
    expect_out("rst_vs_thresh", 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 10'd0);
    set_gs(GS_RUN);
    expect_out("rst_vs_thresh2", 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 10'd0);

    // Leaving RUN clears the partial count and restarts grace
    enter_armed();
    fs(1'b1);
    ov(10'd70, 9'd70);
    ov(10'd71, 9'd70);
    set_gs(GS_READY);
    set_gs(GS_RUN);
    fs(1'b1);
    ov(10'd80, 9'd80);
    fs(1'b1);
    ov(10'd81, 9'd80);
    ov(10'd82, 9'd80);
    ov(10'd83, 9'd80);
    expect_out("rearm_grace", 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 10'd0);
    fs(1'b1);
    ov(10'd90, 9'd90);
    ov(10'd91, 9'd90);
    ov(10'd92, 9'd90);
    expect_out("rearm_hit", 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 10'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
